// File: rtl/codeword_tx.sv
// Serial "1..10" codeword transmitter: emits num_words codewords of ONES 1-bits plus a
// trailing 0, separated by gap 0-bits, then pulses done.
module codeword_tx #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4,
    parameter int ONES  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [GAP_W-1:0] gap,
    output logic             level,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent,
    output logic [2:0]       state
);

    // 4 bits covers the full legal ONES range of 1..15.
    localparam int               BIT_W    = 4;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ONES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_HIGH = 3'b001,
        S_LOW  = 3'b010,
        S_GAP  = 3'b011,
        S_FIN  = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   words_inc;

    assign words_inc = words_q + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        gap_d     = gap_q;
        num_d     = num_q;
        words_d   = words_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d = '0;
                    if (num_words != '0) begin
                        num_d     = num_words;
                        gap_d     = gap;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = S_HIGH;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end

            S_HIGH: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = S_LOW;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            S_LOW: begin
                words_d = words_inc;
                if (words_inc == num_q) begin
                    state_d = S_FIN;
                end else if (gap_q == '0) begin
                    state_d = S_HIGH;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                // GAP is only entered with gap_q != 0, so gap_q - 1 cannot underflow here.
                if (gap_cnt_q == gap_q - GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_HIGH;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every register, including the latched configuration, is cleared by the
    // asynchronous reset so a mid-transmission reset leaves no stale word count behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            words_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the values
            // computed from the same pre-edge state.
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            gap_q     <= gap_d;
            num_q     <= num_d;
            words_q   <= words_d;
        end
    end

    // Moore outputs decoded purely from registered state.
    assign level      = (state_q == S_HIGH);
    assign busy       = (state_q == S_HIGH) || (state_q == S_LOW) || (state_q == S_GAP);
    assign done       = (state_q == S_FIN);
    assign words_sent = words_q;
    assign state      = state_q;

endmodule

// File: tb/tb_codeword_tx.sv
// Self-checking bench for codeword_tx: per-cycle expected traces built from the
// codeword framing rules, plus a simple run-length codeword detector on level.
module tb_codeword_tx;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam int ONES  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [GAP_W-1:0] gap;
    logic             level;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_sent;
    logic [2:0]       state;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        logic             level;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] words;
        logic [2:0]       st;
    } cyc_t;

    cyc_t exp_q[$];

    codeword_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W), .ONES(ONES)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .gap        (gap),
        .level      (level),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input cyc_t e);
        check({tag, ".level"}, 32'(level), 32'(e.level));
        check({tag, ".busy"},  32'(busy),  32'(e.busy));
        check({tag, ".done"},  32'(done),  32'(e.done));
        check({tag, ".words"}, 32'(words_sent), 32'(e.words));
        check({tag, ".state"}, 32'(state), 32'(e.st));
    endtask

    task automatic push(input logic l, input logic b, input logic d, input int w, input int st);
        cyc_t c;
        c.level = l;
        c.busy  = b;
        c.done  = d;
        c.words = CNT_W'(w);
        c.st    = 3'(st);
        exp_q.push_back(c);
    endtask

    // Expected cycles after start is accepted: per word ONES high bits and one low bit
    // (count bumps on leaving the low bit), gap zeros between words, then FIN and IDLE.
    task automatic build(input int n, input int g);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < ONES; b++) push(1'b1, 1'b1, 1'b0, w, 1);
            push(1'b0, 1'b1, 1'b0, w, 2);
            if (w < n - 1)
                for (int j = 0; j < g; j++) push(1'b0, 1'b1, 1'b0, w + 1, 3);
        end
        push(1'b0, 1'b0, 1'b1, n, 4);
        push(1'b0, 1'b0, 1'b0, n, 0);
    endtask

    // hold: keep start high through FIN to exercise re-trigger from IDLE.
    // poke: index where start is pulsed with num_words=7 mid-transmission (-1 = none).
    // rst_at: index where reset is asserted mid-cycle, aborting the trace (-1 = none).
    task automatic run_txn(input string tag, input int n, input int g, input bit hold,
                           input int poke, input int rst_at, output int det);
        int drop = 0;
        int run  = 0;
        det = 0;
        exp_q.delete();
        build(n, g);
        if (hold) begin
            drop = exp_q.size();
            build(n, g);
        end
        @(negedge clk);
        start     = 1'b1;
        num_words = CNT_W'(n);
        gap       = GAP_W'(g);
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cycle(tag, exp_q[i]);
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1;
                check({tag, ".rst_level"}, 32'(level), 32'd0);
                check({tag, ".rst_busy"},  32'(busy),  32'd0);
                check({tag, ".rst_words"}, 32'(words_sent), 32'd0);
                check({tag, ".rst_state"}, 32'(state), 32'd0);
                start     = 1'b0;
                num_words = CNT_W'(n);
                repeat (2) begin
                    @(negedge clk);
                    check({tag, ".rst_nodone"}, 32'(done), 32'd0);
                    check({tag, ".rst_hold_lvl"}, 32'(level), 32'd0);
                end
                reset = 1'b0;
                @(negedge clk);
                check({tag, ".post_rst_done"},  32'(done),  32'd0);
                check({tag, ".post_rst_words"}, 32'(words_sent), 32'd0);
                check({tag, ".post_rst_state"}, 32'(state), 32'd0);
                return;
            end
            if (level) run++;
            else begin
                if (run == ONES) det++;
                run = 0;
            end
            if (i == drop) start = 1'b0;
            if (poke >= 0 && i == poke) begin
                start     = 1'b1;
                num_words = CNT_W'(7);
            end
            if (poke >= 0 && i == poke + 1) begin
                start     = 1'b0;
                num_words = CNT_W'(n);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int det;
        int n;
        int g;

        reset     = 1'b1;
        start     = 1'b0;
        num_words = '0;
        gap       = '0;

        // Reset and idle.
        #2;
        check("rst.level", 32'(level), 32'd0);
        check("rst.state", 32'(state), 32'd0);
        #10 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle.level", 32'(level), 32'd0);
            check("idle.busy",  32'(busy),  32'd0);
            check("idle.done",  32'(done),  32'd0);
            check("idle.words", 32'(words_sent), 32'd0);
            check("idle.state", 32'(state), 32'd0);
        end

        // Single word, no gap.
        run_txn("one_word", 1, 0, 1'b0, -1, -1, det);
        check("one_word.det", 32'(det), 32'd1);

        // Two words with a gap of 2.
        run_txn("two_gap2", 2, 2, 1'b0, -1, -1, det);
        check("two_gap2.det", 32'(det), 32'd2);

        // Zero words: straight to FIN.
        run_txn("zero", 0, 3, 1'b0, -1, -1, det);
        check("zero.det", 32'(det), 32'd0);

        // Three words gap 1: start re-pulsed mid-word with num_words=7, then reset
        // during the second word's HIGH phase.
        run_txn("poke_rst", 3, 1, 1'b0, 1, 6, det);

        // Same config without reset: the mid-word poke must not change the stream.
        run_txn("poke", 3, 1, 1'b0, 1, -1, det);
        check("poke.det", 32'(det), 32'd3);

        // Loopback: five back-to-back codewords.
        run_txn("loop5", 5, 0, 1'b0, -1, -1, det);
        check("loop5.det", 32'(det), 32'd5);
        check("loop5.words", 32'(words_sent), 32'd5);

        // start held high re-triggers one cycle after FIN.
        run_txn("hold", 1, 0, 1'b1, -1, -1, det);
        check("hold.det", 32'(det), 32'd2);

        // Boundaries: maximum gap and maximum word count.
        run_txn("gap_max", 2, 15, 1'b0, -1, -1, det);
        check("gap_max.det", 32'(det), 32'd2);
        run_txn("cnt_max", 255, 0, 1'b0, -1, -1, det);
        check("cnt_max.det", 32'(det), 32'd255);

        // Randomised transactions.
        repeat (12) begin
            n = int'($urandom_range(0, 6));
            g = int'($urandom_range(0, 5));
            run_txn("rand", n, g, 1'b0, -1, -1, det);
            check("rand.det", 32'(det), 32'(n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/codeword_tx.md
Name: codeword_tx

Overview:
- Serial transmitter that generates the "1110" codeword stream consumed by the team's codeword detector and count path.
- On a start request it emits a programmed number of codewords on a single-bit `level` line. Each codeword is ONES consecutive 1s followed by one 0, and consecutive codewords are separated by a programmable run of 0s.
- It signals completion with `done` and reports a running count of words sent.
- Used as the stimulus source and loopback partner for the detector on the board.

Parameters:
- CNT_W, 8, width of `num_words` and `words_sent`.
- GAP_W, 4, width of `gap`.
- ONES, 3, number of 1 bits per codeword; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- num_words  input  CNT_W  codewords to send; sampled with start.
- gap  input  GAP_W  idle 0-bits between codewords; sampled with start.
- level  output  1  serial codeword stream.
- busy  output  1  high while a transmission is in progress.
- done  output  1  one-cycle pulse when a transmission finishes.
- words_sent  output  CNT_W  codewords fully emitted in the current/last transmission.
- state  output  3  current state encoding, for test.

Behaviour:
- Reset (async, immediate): state=IDLE, level=0, busy=0, done=0, words_sent=0, all internal counters and latched config cleared.
- Outputs are Moore, decoded from registered state/counters. No combinational path from inputs to outputs.
- States:
  - IDLE=000
  - HIGH=001
  - LOW=010
  - GAP=011
  - FIN=100
  - 101–111 are illegal and return to IDLE on the next edge.
- IDLE: level=0, busy=0.
  - start=1 and num_words!=0 at edge k: latch num_words and gap, clear words_sent and the bit counter, go to HIGH.
  - start=1 and num_words=0: go to FIN; no bits are sent, words_sent is cleared to 0.
  - start=0: stay in IDLE.
- HIGH: level=1, busy=1, for exactly ONES cycles (bit counter 0..ONES-1), then go to LOW.
- LOW: level=0, busy=1, for one cycle. On exit, words_sent increments by 1. Next state:
  - if words_sent+1 == latched num_words: FIN;
  - else if latched gap == 0: HIGH;
  - else: GAP.
- GAP: level=0, busy=1, for exactly `gap` cycles, then go to HIGH with the bit counter cleared.
- FIN: level=0, busy=0, done=1 for one cycle, then go to IDLE.
- Latency: after start is accepted at edge k, level=1 during cycles k+1..k+ONES.
- Total busy cycles = N*(ONES+1) + (N-1)*gap. done follows in the next cycle. No trailing gap after the last word.
- start while busy or in FIN is ignored; there is no queuing. start held high re-triggers from IDLE, i.e. in the cycle after FIN.
- num_words and gap changes during a transmission have no effect, because the latched copies are used.
- words_sent holds its final value after done until the next accepted start.
- words_sent arithmetic is CNT_W-bit unsigned. It cannot wrap, since the count ≤ num_words ≤ 2^CNT_W-1.
- Reset mid-transmission: level drops to 0 immediately, no done pulse is produced, and words_sent=0.

Test Plan:
1. Reset then idle 5 cycles -> level=0, busy=0, done=0, words_sent=0, state=000 throughout.
2. start for 1 cycle with num_words=1, gap=0 -> level=1,1,1,0 on the next 4 cycles with busy=1, then done=1 for 1 cycle with busy=0, words_sent=1.
3. num_words=2, gap=2 -> level sequence 1110 00 1110, total 10 busy cycles, words_sent steps 0→1→2, single done pulse.
4. start with num_words=0 -> done=1 on the next cycle, level stays 0, busy never asserts, words_sent=0.
5. num_words=3, gap=1; pulse start again mid-word and change num_words to 7 -> stream and word count unaffected (3 words, words_sent=3); reset asserted during the 2nd word's HIGH -> level=0 immediately, words_sent=0, no done.
6. Loopback to detector + counter: num_words=5, gap=0 -> detector flags 5 codewords, counter reads 5, words_sent=5.
